// File: rtl/program_sequencer.sv
// Program sequencer: streams a loaded program into the processor
// over the Din/run/done handshake, one instruction at a time.
module program_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [1:0]        proc_step,
  input  logic              proc_done,
  output logic [DATA_W-1:0] din,
  output logic              run,
  output logic              busy,
  output logic              finished,
  output logic              error,
  output logic [ADDR_W:0]   pc,
  output logic [15:0]       instr_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    IMM,
    WAIT
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  state_t            state, state_n;
  logic [ADDR_W:0]   len_q, len_n;
  logic [ADDR_W:0]   pc_n, pc_inc;
  logic [15:0]       ic_n;
  logic              err_n, fin_n;
  logic [DATA_W-1:0] word;
  logic              is_mvi, fetch;

  assign word   = mem[pc[ADDR_W-1:0]];
  assign is_mvi = (word[DATA_W-1 -: 3] == 3'b001);
  assign fetch  = (state == ISSUE) && (proc_step == 2'd0);
  assign pc_inc = pc + ONE;
  assign busy   = (state != IDLE);

  // Program memory: written from the host path only while idle.
  always_ff @(posedge clock) begin
    if (load_en && state == IDLE)
      mem[load_addr] <= load_data;
  end

  // State and bookkeeping registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      len_q       <= '0;
      pc          <= '0;
      instr_count <= '0;
      error       <= 1'b0;
      finished    <= 1'b0;
    end else begin
      state       <= state_n;
      len_q       <= len_n;
      pc          <= pc_n;
      instr_count <= ic_n;
      error       <= err_n;
      finished    <= fin_n;
    end
  end

  // Next-state decode; a truncated mvi drops run in its own cycle.
  always_comb begin
    state_n = state;
    len_n   = len_q;
    pc_n    = pc;
    ic_n    = instr_count;
    err_n   = error;
    fin_n   = 1'b0;
    run     = 1'b0;
    din     = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (prog_len == '0) begin
            fin_n = 1'b1;
          end else if (prog_len > DEPTH) begin
            err_n = 1'b1;
          end else begin
            len_n   = prog_len;
            pc_n    = '0;
            ic_n    = '0;
            err_n   = 1'b0;
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        din = word;
        run = 1'b1;
        if (fetch) begin
          if (!is_mvi) begin
            pc_n    = pc_inc;
            state_n = WAIT;
          end else if (pc_inc < len_q) begin
            pc_n    = pc_inc;
            state_n = IMM;
          end else begin
            run     = 1'b0;
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      IMM: begin
        din  = word;
        pc_n = pc_inc;
        ic_n = instr_count + 16'd1;
        if (!proc_done) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (pc_inc >= len_q) begin
          fin_n   = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = ISSUE;
        end
      end
      WAIT: begin
        if (proc_done) begin
          ic_n = instr_count + 16'd1;
          if (pc >= len_q) begin
            fin_n   = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Instruction feeder that drives the other end of the processor's Din/run/done interface.
- Holds a small loadable program memory and streams the program to the processor one instruction at a time.
- Asserts run at the processor's fetch step, supplies the mvi immediate word on the following cycle, and waits for done before issuing the next instruction.
- Sits between the board/host load path and the processor's Din, run, done and step pins.

Parameters:
ADDR_W, 5, program memory address width (depth 2^ADDR_W words)
DATA_W, 16, instruction/immediate word width; must equal processor Din width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
load_en  in  1  write program word this cycle (honoured only when busy=0)
load_addr  in  ADDR_W  program memory write address
load_data  in  DATA_W  program word to write
start  in  1  begin executing words 0..prog_len-1 (honoured only when busy=0)
prog_len  in  ADDR_W+1  program length in words, immediates included
proc_step  in  2  processor step counter
proc_done  in  1  processor done
din  out  DATA_W  word driven onto the processor Din
run  out  1  processor run
busy  out  1  high in every state except IDLE
finished  out  1  one-cycle pulse on normal completion
error  out  1  sticky flag: truncated mvi; cleared by start or reset
pc  out  ADDR_W+1  address of the next word to read
instr_count  out  16  instructions completed since start; wraps at 2^16

Behaviour:
- Reset: state=IDLE; din=0, run=0, busy=0, finished=0, error=0, pc=0, instr_count=0. Memory contents are not cleared.
- Reset mid-run: abandon the run the next cycle. The processor is reset by the same reset.
- Memory: synchronous write, asynchronous read. A load_en in a cycle with busy=1 is ignored.
- Instruction decode: opcode = word[15:13]. Opcode 3'b001 (mvi) is the only two-word instruction.
- IDLE: run=0, din=0.
  - On start with prog_len=0: pulse finished next cycle, stay IDLE.
  - On start with prog_len>2^ADDR_W: set error, stay IDLE.
  - Otherwise: pc<=0, instr_count<=0, error<=0, go to ISSUE.
- ISSUE: din=mem[pc], run=1. The fetch cycle is the cycle with proc_step==0; hold in ISSUE until it occurs. On the fetch cycle:
  - If opcode≠mvi: pc<=pc+1, go to WAIT.
  - If opcode=mvi and pc+1<prog_len: pc<=pc+1, go to IMM.
  - If opcode=mvi and pc+1>=prog_len: set error, drop run, go to IDLE with no finished pulse. The error is detected combinationally in the same cycle, so the processor must not see run=1.
  - proc_done seen in ISSUE is ignored.
- IMM: exactly one cycle, coincides with processor step 1. din=mem[pc] (the immediate), run=0. pc<=pc+1, instr_count++.
  - If proc_done=0 this cycle, set error and go to IDLE (protocol violation).
  - Otherwise go to NEXT.
- WAIT: din=0, run=0. Stay until proc_done=1. On done: instr_count++, go to NEXT.
- NEXT: a combinational decision taken in the same cycle as the done, not a separate state.
  - If pc>=prog_len: finished pulse next cycle, go to IDLE.
  - Else go to ISSUE. The processor step clears to 0 on done, so the next fetch occurs the cycle after done with zero dead cycles.
- Throughput:
  - mv: 2 cycles.
  - mvi: 2 cycles, 2 words.
  - ALU ops: 4 cycles.
- start while busy is ignored. finished and error are never both set by the same run.
- pc never exceeds prog_len; no wrap inside a run.

Test Plan:
- Load [0]=16'h2000 (mvi R0), [1]=16'h0005, prog_len=2, start. Expect: run=1 for one cycle with din=2000 at step 0; next cycle din=0005, done; finished pulse; instr_count=1; pc=2.
- Load mvi R0,#5 (2000,0005), mvi R1,#3 (2400,0003), add R0,R1 (4080), mv R2,R0 (0800), prog_len=6. Expect: R2=8 in processor; instr_count=4; finished one pulse; total cycles from first fetch to finished = 2+2+4+2 (±1 for the finished register).
- Hold proc_step at 2 while in ISSUE for 3 cycles. Expect: run stays 1, pc unchanged; fetch advances only once step==0.
- prog_len=1 with [0]=2000. Expect: run never asserted; error=1 next cycle, busy=0, no finished pulse. A subsequent start clears error.
- Assert reset during WAIT of an add. Expect next cycle: IDLE, run=0, pc=0, instr_count=0. Memory still holds the program; restart reproduces results.
- load_en with load_addr=0, load_data=FFFF while busy. Expect: mem[0] unchanged. start while busy: no restart, pc continues.
